// File: rtl/wb_stage.sv
// MEM/WB pipeline register with load extraction and writeback mux.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_rfwr,
    input  logic [4:0]  mem_rd,
    input  logic [1:0]  mem_wdsel,
    input  logic [31:0] mem_alu,
    input  logic [31:0] mem_ldata,
    input  logic [31:0] mem_pc,
    input  logic [2:0]  mem_dmtype,
    input  logic [1:0]  mem_addr_lo,
    input  logic        stall,
    input  logic        flush,
    output logic        rf_wr,
    output logic [4:0]  rf_a3,
    output logic [31:0] rf_wd,
    output logic        wb_valid,
    output logic [31:0] wb_pc
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0] retire_cnt
`endif
);

    typedef enum logic [2:0] {
        DM_LW  = 3'b000,
        DM_LH  = 3'b001,
        DM_LHU = 3'b010,
        DM_LB  = 3'b011,
        DM_LBU = 3'b100
    } dmtype_e;

    logic        valid_q, valid_d;
    logic        rfwr_q, rfwr_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] data_q, data_d;
    logic [31:0] pc_q, pc_d;

    logic [15:0] half;
    logic [7:0]  byte_sel;
    logic [31:0] load_val;
    logic [31:0] wdata;

    always_comb begin
        half     = mem_addr_lo[1] ? mem_ldata[31:16] : mem_ldata[15:0];
        byte_sel = 8'h00;
        case (mem_addr_lo)
            2'd0: byte_sel = mem_ldata[7:0];
            2'd1: byte_sel = mem_ldata[15:8];
            2'd2: byte_sel = mem_ldata[23:16];
            2'd3: byte_sel = mem_ldata[31:24];
            default: byte_sel = 8'h00;
        endcase
        case (dmtype_e'(mem_dmtype))
            DM_LH:   load_val = {{16{half[15]}}, half};
            DM_LHU:  load_val = {16'h0000, half};
            DM_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
            DM_LBU:  load_val = {24'h000000, byte_sel};
            default: load_val = mem_ldata;
        endcase
    end

    always_comb begin
        case (mem_wdsel)
            2'b01:   wdata = load_val;
            2'b10:   wdata = mem_pc + 32'd4;
            default: wdata = mem_alu;
        endcase
    end

    // rst is applied in the flop block; here flush beats stall beats capture.
    always_comb begin
        valid_d = valid_q;
        rfwr_d  = rfwr_q;
        rd_d    = rd_q;
        data_d  = data_q;
        pc_d    = pc_q;
        if (flush) begin
            valid_d = 1'b0;
            rfwr_d  = 1'b0;
            rd_d    = 5'd0;
            data_d  = 32'h0;
            pc_d    = 32'h0;
        end else if (!stall) begin
            valid_d = mem_valid;
            rfwr_d  = mem_rfwr;
            rd_d    = mem_rd;
            data_d  = wdata;
            pc_d    = mem_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            rfwr_q  <= 1'b0;
            rd_q    <= 5'd0;
            data_q  <= 32'h0;
            pc_q    <= 32'h0;
        end else begin
            valid_q <= valid_d;
            rfwr_q  <= rfwr_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        rf_wr    = valid_q & rfwr_q & (rd_q != 5'd0);
        rf_a3    = rf_wr ? rd_q : 5'd0;
        rf_wd    = rf_wr ? data_q : 32'h0;
        wb_valid = valid_q;
        wb_pc    = valid_q ? pc_q : 32'h0;
    end

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt_q, retire_cnt_d;

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (!flush && !stall && mem_valid)
            retire_cnt_d = retire_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) retire_cnt_q <= 32'h0;
        else     retire_cnt_q <= retire_cnt_d;
    end

    assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: reset, writeback mux, load extraction, stall/flush/reset.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst, mem_valid, mem_rfwr, stall, flush;
    logic [4:0]  mem_rd;
    logic [1:0]  mem_wdsel, mem_addr_lo;
    logic [31:0] mem_alu, mem_ldata, mem_pc;
    logic [2:0]  mem_dmtype;
    logic        rf_wr, wb_valid;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd, wb_pc;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_cnt = 32'h0;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_rfwr(mem_rfwr),
        .mem_rd(mem_rd), .mem_wdsel(mem_wdsel), .mem_alu(mem_alu),
        .mem_ldata(mem_ldata), .mem_pc(mem_pc), .mem_dmtype(mem_dmtype),
        .mem_addr_lo(mem_addr_lo), .stall(stall), .flush(flush),
        .rf_wr(rf_wr), .rf_a3(rf_a3), .rf_wd(rf_wd),
        .wb_valid(wb_valid), .wb_pc(wb_pc)
`ifdef WB_RETIRE_CNT_EN
        , .retire_cnt(retire_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic chk_cnt(input string tag);
`ifdef WB_RETIRE_CNT_EN
        chk(tag, retire_cnt, exp_cnt);
`endif
    endtask

    // Expected retire count follows the capture rule independently of the DUT.
    task automatic tick();
        if (rst) exp_cnt = 32'h0;
        else if (!flush && !stall && mem_valid) exp_cnt = exp_cnt + 32'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic w, input logic [4:0] rd,
                       input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] pc,
                       input logic [2:0] dm, input logic [1:0] lo);
        mem_valid = v; mem_rfwr = w; mem_rd = rd; mem_wdsel = sel;
        mem_alu = alu; mem_pc = pc; mem_dmtype = dm; mem_addr_lo = lo;
    endtask

    typedef struct {
        logic [2:0]  dm;
        logic [1:0]  lo;
        logic [31:0] exp;
    } ld_vec_t;

    ld_vec_t lv [11];

    initial begin
        lv[0]  = '{3'b011, 2'd0, 32'h0000_0001};
        lv[1]  = '{3'b011, 2'd1, 32'h0000_007F};
        lv[2]  = '{3'b011, 2'd2, 32'hFFFF_FFFF};
        lv[3]  = '{3'b011, 2'd3, 32'hFFFF_FF80};
        lv[4]  = '{3'b100, 2'd3, 32'h0000_0080};
        lv[5]  = '{3'b001, 2'd2, 32'hFFFF_80FF};
        lv[6]  = '{3'b010, 2'd0, 32'h0000_7F01};
        lv[7]  = '{3'b001, 2'd3, 32'hFFFF_80FF};
        lv[8]  = '{3'b010, 2'd1, 32'h0000_7F01};
        lv[9]  = '{3'b000, 2'd3, 32'h80FF_7F01};
        lv[10] = '{3'b111, 2'd2, 32'h80FF_7F01};

        rst = 1'b1; stall = 1'b0; flush = 1'b0; mem_ldata = 32'h0;
        drv(1'b1, 1'b1, 5'd3, 2'b00, 32'hDEAD_BEEF, 32'h40, 3'b000, 2'd0);
        tick();
        tick();
        chk("rst_rf_wr", {31'h0, rf_wr}, 32'h0);
        chk("rst_rf_a3", {27'h0, rf_a3}, 32'h0);
        chk("rst_rf_wd", rf_wd, 32'h0);
        chk("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
        chk("rst_wb_pc", wb_pc, 32'h0);
        chk_cnt("rst_cnt");

        rst = 1'b0;
        drv(1'b1, 1'b1, 5'd5, 2'b00, 32'h1234_5678, 32'h100, 3'b000, 2'd0);
        tick();
        chk("alu_rf_wr", {31'h0, rf_wr}, 32'h1);
        chk("alu_rf_a3", {27'h0, rf_a3}, 32'd5);
        chk("alu_rf_wd", rf_wd, 32'h1234_5678);
        chk("alu_wb_valid", {31'h0, wb_valid}, 32'h1);
        chk("alu_wb_pc", wb_pc, 32'h100);
        chk("alu_cnt_model", exp_cnt, 32'd1);
        chk_cnt("alu_cnt");

        mem_ldata = 32'h80FF_7F01;
        for (int i = 0; i < 11; i++) begin
            drv(1'b1, 1'b1, 5'd3, 2'b01, 32'h5555_5555, 32'h200, lv[i].dm, lv[i].lo);
            tick();
            chk($sformatf("load%0d_wd", i), rf_wd, lv[i].exp);
        end
        chk_cnt("load_cnt");

        drv(1'b1, 1'b1, 5'd4, 2'b11, 32'hCAFE_0011, 32'h300, 3'b000, 2'd0);
        tick();
        chk("sel11_wd", rf_wd, 32'hCAFE_0011);

        drv(1'b1, 1'b1, 5'd1, 2'b10, 32'h0, 32'hFFFF_FFFC, 3'b000, 2'd0);
        tick();
        chk("pc4_wrap_wd", rf_wd, 32'h0);
        chk("pc4_wrap_wr", {31'h0, rf_wr}, 32'h1);
        chk("pc4_wrap_pc", wb_pc, 32'hFFFF_FFFC);

        drv(1'b1, 1'b1, 5'd2, 2'b10, 32'h0, 32'h0000_1000, 3'b000, 2'd0);
        tick();
        chk("pc4_wd", rf_wd, 32'h0000_1004);

        drv(1'b1, 1'b1, 5'd0, 2'b00, 32'h1111_2222, 32'h400, 3'b000, 2'd0);
        tick();
        chk("rd0_wr", {31'h0, rf_wr}, 32'h0);
        chk("rd0_wd", rf_wd, 32'h0);
        chk("rd0_a3", {27'h0, rf_a3}, 32'h0);
        chk("rd0_valid", {31'h0, wb_valid}, 32'h1);

        drv(1'b1, 1'b0, 5'd9, 2'b00, 32'h3333_4444, 32'h404, 3'b000, 2'd0);
        tick();
        chk("norfwr_wr", {31'h0, rf_wr}, 32'h0);
        chk("norfwr_a3", {27'h0, rf_a3}, 32'h0);
        chk("norfwr_pc", wb_pc, 32'h404);

        drv(1'b1, 1'b1, 5'd7, 2'b00, 32'hAAAA_5555, 32'h500, 3'b000, 2'd0);
        tick();
        chk("st_pre_a3", {27'h0, rf_a3}, 32'd7);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 1'b1, 5'd8 + 5'(i), 2'b00, 32'h0BAD_0000 + 32'(i), 32'h600 + 32'(i), 3'b000, 2'd0);
            tick();
            chk($sformatf("stall%0d_wr", i), {31'h0, rf_wr}, 32'h1);
            chk($sformatf("stall%0d_a3", i), {27'h0, rf_a3}, 32'd7);
            chk($sformatf("stall%0d_wd", i), rf_wd, 32'hAAAA_5555);
            chk($sformatf("stall%0d_pc", i), wb_pc, 32'h500);
            chk_cnt($sformatf("stall%0d_cnt", i));
        end
        stall = 1'b0;
        drv(1'b1, 1'b1, 5'd8, 2'b00, 32'h0000_0808, 32'h700, 3'b000, 2'd0);
        tick();
        chk("post_stall_a3", {27'h0, rf_a3}, 32'd8);
        chk("post_stall_wd", rf_wd, 32'h0000_0808);

        flush = 1'b1; stall = 1'b1;
        drv(1'b1, 1'b1, 5'd9, 2'b00, 32'h9999_9999, 32'h800, 3'b000, 2'd0);
        tick();
        chk("flush_valid", {31'h0, wb_valid}, 32'h0);
        chk("flush_wr", {31'h0, rf_wr}, 32'h0);
        chk("flush_wd", rf_wd, 32'h0);
        chk("flush_pc", wb_pc, 32'h0);
        chk_cnt("flush_cnt");
        flush = 1'b0; stall = 1'b0;

        drv(1'b0, 1'b1, 5'd10, 2'b00, 32'h7777_0000, 32'h900, 3'b000, 2'd0);
        tick();
        chk("bubble_valid", {31'h0, wb_valid}, 32'h0);
        chk("bubble_wr", {31'h0, rf_wr}, 32'h0);

        drv(1'b1, 1'b1, 5'd11, 2'b00, 32'h7777_1111, 32'hA00, 3'b000, 2'd0);
        tick();
        chk("pre_rst_wr", {31'h0, rf_wr}, 32'h1);
        rst = 1'b1; stall = 1'b1;
        drv(1'b1, 1'b1, 5'd12, 2'b00, 32'h7777_2222, 32'hB00, 3'b000, 2'd0);
        tick();
        chk("mid_rst_wr", {31'h0, rf_wr}, 32'h0);
        chk("mid_rst_a3", {27'h0, rf_a3}, 32'h0);
        chk("mid_rst_wd", rf_wd, 32'h0);
        chk("mid_rst_valid", {31'h0, wb_valid}, 32'h0);
        chk("mid_rst_pc", wb_pc, 32'h0);
        chk_cnt("mid_rst_cnt");
        rst = 1'b0; stall = 1'b0;
        drv(1'b0, 1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 3'b000, 2'd0);
        tick();
        chk("idle_valid", {31'h0, wb_valid}, 32'h0);
        chk_cnt("idle_cnt");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
